// File: rtl/vload_seq_if.sv
// Bundle of the vector-load sequencer's command, memory and register-file ports.
// The master side is the sequencer; the slave side is the issuer/memory/vregs environment.
interface vload_seq_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [15:0]  cmd_base;
  logic [3:0]   cmd_vreg;
  logic [3:0]   cmd_len;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [15:0]  mem_req_addr;
  logic         mem_resp_valid;
  logic [15:0]  mem_resp_data;
  logic         wEn;
  logic [3:0]   wAddr;
  logic [3:0]   wLen;
  logic [255:0] wData;
  logic         busy;

  modport master (
    input  cmd_valid, cmd_base, cmd_vreg, cmd_len,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output cmd_ready, mem_req_valid, mem_req_addr,
    output wEn, wAddr, wLen, wData, busy
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_vreg, cmd_len,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  cmd_ready, mem_req_valid, mem_req_addr,
    input  wEn, wAddr, wLen, wData, busy
  );
endinterface

// File: rtl/vload_seq.sv
// Vector load sequencer: fetches len+1 16-bit words from memory, packs them into a
// 256-bit vector and writes it to the vector register file in a single wEn cycle.
module vload_seq (
  input  logic        clk,
  input  logic        rst_n,
  vload_seq_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   base_q, base_d;
  logic [3:0]    vreg_q, vreg_d;
  logic [3:0]    len_q, len_d;
  logic [4:0]    req_cnt_q, req_cnt_d;
  logic [4:0]    resp_cnt_q, resp_cnt_d;
  logic [255:0]  buf_q, buf_d;
  logic [255:0]  wdata_q, wdata_d;
  logic [3:0]    waddr_q, waddr_d;
  logic [3:0]    wlen_q, wlen_d;

  logic          req_pending;
  logic          resp_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      vreg_q     <= '0;
      len_q      <= '0;
      req_cnt_q  <= '0;
      resp_cnt_q <= '0;
      buf_q      <= '0;
      wdata_q    <= '0;
      waddr_q    <= '0;
      wlen_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      vreg_q     <= vreg_d;
      len_q      <= len_d;
      req_cnt_q  <= req_cnt_d;
      resp_cnt_q <= resp_cnt_d;
      buf_q      <= buf_d;
      wdata_q    <= wdata_d;
      waddr_q    <= waddr_d;
      wlen_q     <= wlen_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    vreg_d     = vreg_q;
    len_d      = len_q;
    req_cnt_d  = req_cnt_q;
    resp_cnt_d = resp_cnt_q;
    buf_d      = buf_q;
    wdata_d    = wdata_q;
    waddr_d    = waddr_q;
    wlen_d     = wlen_q;

    req_pending = (state_q == FETCH) && (req_cnt_q <= {1'b0, len_q});
    // Responses past element len are dropped so a stray extra word cannot corrupt the buffer.
    resp_take   = (state_q == FETCH) && bus.mem_resp_valid && (resp_cnt_q <= {1'b0, len_q});

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          base_d     = bus.cmd_base;
          vreg_d     = bus.cmd_vreg;
          len_d      = bus.cmd_len;
          req_cnt_d  = '0;
          resp_cnt_d = '0;
          buf_d      = '0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (req_pending && bus.mem_req_ready) begin
          req_cnt_d = req_cnt_q + 5'd1;
        end
        if (resp_take) begin
          buf_d[{resp_cnt_q[3:0], 4'd0} +: 16] = bus.mem_resp_data;
          resp_cnt_d = resp_cnt_q + 5'd1;
          if (resp_cnt_q[3:0] == len_q) begin
            wdata_d = buf_d;
            waddr_d = vreg_q;
            wlen_d  = len_q;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready     = (state_q == IDLE);
  assign bus.busy          = (state_q != IDLE);
  assign bus.mem_req_valid = req_pending;
  // Address is forced to zero outside FETCH so idle/reset presents a clean bus.
  assign bus.mem_req_addr  = (state_q == FETCH) ? (base_q + 16'(req_cnt_q)) : 16'h0000;
  assign bus.wEn           = (state_q == WRITE);
  assign bus.wAddr         = waddr_q;
  assign bus.wLen          = wlen_q;
  assign bus.wData         = wdata_q;

endmodule

// File: tb/tb_vload_seq.sv
// Bench for vload_seq: memory model, transaction-level scoreboard and directed loads.
module tb_vload_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vload_seq_if vif ();

  vload_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif)
  );

  typedef struct {
    logic [15:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [3:0]   vreg;
    logic [3:0]   len;
    logic [255:0] data;
  } wr_t;

  pend_t       pend_q[$];
  wr_t         exp_w[$];
  wr_t         wr_log[$];
  logic [15:0] exp_addr[$];
  logic [15:0] req_log[$];
  int          hs_log[$];
  int          wen_log[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wen_cnt = 0;
  int req_cnt = 0;
  int resp_seen = 0;
  int hs_cyc = 0;
  int wen_cyc = 0;
  bit bp_mode = 1'b0;
  int clr_req = 0, clr_seen = 0;
  int flush_req = 0, flush_seen = 0;

  bit           model_busy = 1'b0;
  logic [255:0] last_data = '0;
  logic [3:0]   last_vreg = '0;
  logic [3:0]   last_len = '0;
  bit           prev_stall = 1'b0;
  logic [15:0]  prev_addr = '0;

  function automatic logic [15:0] data_fn(input logic [15:0] a);
    return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'hA5A5);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkv(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: in-order responses, latency 1 (or 1..4 with toggling ready in backpressure mode).
  task automatic mem_proc();
    pend_t p;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (flush_req != flush_seen) begin
        flush_seen = flush_req;
        pend_q.delete();
      end
      vif.mem_req_ready = bp_mode ? ~vif.mem_req_ready : 1'b1;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        vif.mem_resp_valid = 1'b1;
        vif.mem_resp_data  = data_fn(pend_q[0].addr);
        pend_q.delete(0);
      end else begin
        vif.mem_resp_valid = 1'b0;
        vif.mem_resp_data  = 16'h0000;
      end
      @(negedge clk);
      if (vif.mem_req_valid && vif.mem_req_ready) begin
        p.addr = vif.mem_req_addr;
        p.due  = cyc + (bp_mode ? int'($urandom_range(1, 4)) : 1);
        pend_q.push_back(p);
      end
    end
  endtask

  // Scoreboard: every command expects len+1 ordered addresses and one packed write.
  task automatic mon_proc();
    wr_t w;
    logic [15:0] a;
    forever begin
      @(negedge clk);
      if (clr_req != clr_seen) begin
        clr_seen = clr_req;
        exp_w.delete();
        exp_addr.delete();
        model_busy = 1'b0;
        last_data  = '0;
        last_vreg  = '0;
        last_len   = '0;
        prev_stall = 1'b0;
      end
      chk("busy", 32'(vif.busy), 32'(model_busy));
      chk("cmd_ready", 32'(vif.cmd_ready), 32'(!model_busy));
      if (!model_busy) chk("req_when_idle", 32'(vif.mem_req_valid), 32'd0);
      if (prev_stall) chk("addr_hold", {15'd0, vif.mem_req_valid, vif.mem_req_addr}, {15'd0, 1'b1, prev_addr});
      if (vif.mem_req_valid && vif.mem_req_ready) begin
        req_log.push_back(vif.mem_req_addr);
        req_cnt++;
        chk("req_expected", 32'(exp_addr.size() > 0), 32'd1);
        if (exp_addr.size() > 0) begin
          a = exp_addr.pop_front();
          chk("req_addr", 32'(vif.mem_req_addr), 32'(a));
        end
      end
      prev_stall = vif.mem_req_valid && !vif.mem_req_ready;
      prev_addr  = vif.mem_req_addr;
      if (vif.mem_resp_valid && model_busy) resp_seen++;
      if (vif.wEn) begin
        wen_cnt++;
        wen_cyc = cyc;
        wen_log.push_back(cyc);
        w.vreg = vif.wAddr; w.len = vif.wLen; w.data = vif.wData;
        wr_log.push_back(w);
        chk("wen_expected", 32'(exp_w.size() > 0), 32'd1);
        if (exp_w.size() > 0) begin
          w = exp_w.pop_front();
          chk("wAddr", 32'(vif.wAddr), 32'(w.vreg));
          chk("wLen", 32'(vif.wLen), 32'(w.len));
          chkv("wData", vif.wData, w.data);
          chk("reqs_all_issued", 32'(exp_addr.size()), 32'd0);
          last_vreg = w.vreg; last_len = w.len; last_data = w.data;
        end
        model_busy = 1'b0;
      end else begin
        chk("w_hold_meta", {24'd0, vif.wAddr, vif.wLen}, {24'd0, last_vreg, last_len});
        chkv("w_hold_data", vif.wData, last_data);
      end
      if (vif.cmd_valid && vif.cmd_ready) begin
        hs_cyc = cyc;
        hs_log.push_back(cyc);
        w.vreg = vif.cmd_vreg; w.len = vif.cmd_len; w.data = '0;
        for (int i = 0; i <= int'(vif.cmd_len); i++) begin
          a = vif.cmd_base + 16'(i);
          exp_addr.push_back(a);
          w.data[i*16 +: 16] = data_fn(a);
        end
        exp_w.push_back(w);
        model_busy = 1'b1;
      end
    end
  endtask

  task automatic send_cmd(input logic [15:0] base, input logic [3:0] vreg, input logic [3:0] len,
                          input bit keep_valid);
    int h0;
    int n;
    h0 = hs_log.size();
    n  = 0;
    vif.cmd_valid = 1'b1;
    vif.cmd_base  = base;
    vif.cmd_vreg  = vreg;
    vif.cmd_len   = len;
    while (hs_log.size() == h0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (!keep_valid) vif.cmd_valid = 1'b0;
    chk("cmd_accepted", 32'(hs_log.size() > h0), 32'd1);
  endtask

  task automatic wait_wen(input int target, input int budget);
    int n;
    n = 0;
    while (wen_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk("wen_timeout", 32'(wen_cnt >= target), 32'd1);
  endtask

  initial begin
    wr_t w;
    int  r0;
    int  n;
    int  k;
    rst_n              = 1'b0;
    vif.cmd_valid      = 1'b0;
    vif.cmd_base       = '0;
    vif.cmd_vreg       = '0;
    vif.cmd_len        = '0;
    vif.mem_req_ready  = 1'b1;
    vif.mem_resp_valid = 1'b0;
    vif.mem_resp_data  = '0;
    fork
      mem_proc();
      mon_proc();
    join_none

    repeat (3) @(posedge clk);
    #2;
    chk("rst_cmd_ready", 32'(vif.cmd_ready), 32'd1);
    chk("rst_busy", 32'(vif.busy), 32'd0);
    chk("rst_req_valid", 32'(vif.mem_req_valid), 32'd0);
    chk("rst_req_addr", 32'(vif.mem_req_addr), 32'd0);
    chk("rst_wEn", 32'(vif.wEn), 32'd0);
    chk("rst_wAddr_wLen", {24'd0, vif.wAddr, vif.wLen}, 32'd0);
    chkv("rst_wData", vif.wData, 256'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // 16-element load, best-case timing
    r0 = req_cnt;
    send_cmd(16'h0100, 4'd5, 4'd15, 1'b0);
    wait_wen(1, 100);
    w = wr_log[wr_log.size()-1];
    chk("t1_latency", 32'(wen_cyc - hs_cyc), 32'd18);
    chk("t1_nreq", 32'(req_cnt - r0), 32'd16);
    chk("t1_first_addr", 32'(req_log[r0]), 32'h0100);
    chk("t1_last_addr", 32'(req_log[r0+15]), 32'h010F);
    chk("t1_vreg", 32'(w.vreg), 32'd5);
    chk("t1_len", 32'(w.len), 32'd15);
    chk("t1_e0", 32'(w.data[15:0]), 32'hA4A5);
    chk("t1_e15", 32'(w.data[255:240]), 32'hA4AA);
    repeat (2) @(posedge clk);
    #2;

    // Single element
    r0 = req_cnt;
    send_cmd(16'h0040, 4'd3, 4'd0, 1'b0);
    wait_wen(2, 100);
    w = wr_log[wr_log.size()-1];
    chk("t2_nreq", 32'(req_cnt - r0), 32'd1);
    chk("t2_len", 32'(w.len), 32'd0);
    chkv("t2_data", w.data, {240'd0, 16'hBEEF});

    // Backpressure with variable latency
    bp_mode = 1'b1;
    r0 = req_cnt;
    send_cmd(16'h0300, 4'd7, 4'd9, 1'b0);
    wait_wen(3, 400);
    bp_mode = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    w = wr_log[wr_log.size()-1];
    chk("t3_nreq", 32'(req_cnt - r0), 32'd10);
    chk("t3_single_wen", 32'(wen_cnt), 32'd3);
    chk("t3_e9", 32'(w.data[159:144]), 32'hA6AC);
    chk("t3_upper_zero", 32'(w.data[255:160] == '0), 32'd1);

    // Address wrap
    r0 = req_cnt;
    send_cmd(16'hFFFC, 4'd4, 4'd7, 1'b0);
    wait_wen(4, 100);
    w = wr_log[wr_log.size()-1];
    chk("t4_addr3", 32'(req_log[r0+3]), 32'hFFFF);
    chk("t4_addr4", 32'(req_log[r0+4]), 32'h0000);
    chk("t4_addr7", 32'(req_log[r0+7]), 32'h0003);
    chk("t4_e3", 32'(w.data[63:48]), 32'h5A5A);
    chk("t4_e4", 32'(w.data[79:64]), 32'hA5A5);
    repeat (2) @(posedge clk);
    #2;

    // Reset mid-fetch
    r0 = resp_seen;
    send_cmd(16'h0400, 4'd9, 4'd15, 1'b0);
    n = 0;
    while (resp_seen - r0 < 3 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk("t5_resp_wait", 32'(resp_seen - r0 >= 3), 32'd1);
    rst_n = 1'b0;
    clr_req++;
    flush_req++;
    #1;
    chk("t5_busy", 32'(vif.busy), 32'd0);
    chk("t5_cmd_ready", 32'(vif.cmd_ready), 32'd1);
    chk("t5_req", {15'd0, vif.mem_req_valid, vif.mem_req_addr}, 32'd0);
    chk("t5_wEn", 32'(vif.wEn), 32'd0);
    chk("t5_wAddr_wLen", {24'd0, vif.wAddr, vif.wLen}, 32'd0);
    chkv("t5_wData", vif.wData, 256'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    chk("t5_no_wen", 32'(wen_cnt), 32'd4);
    send_cmd(16'h0500, 4'd2, 4'd1, 1'b0);
    wait_wen(5, 100);
    w = wr_log[wr_log.size()-1];
    chk("t5_vreg", 32'(w.vreg), 32'd2);
    chkv("t5_data", w.data, {224'd0, 16'hA0A4, 16'hA0A5});
    repeat (2) @(posedge clk);
    #2;

    // Busy rejection and back-to-back issue with cmd_valid held
    send_cmd(16'h0600, 4'd1, 4'd2, 1'b1);
    send_cmd(16'h0700, 4'd2, 4'd3, 1'b0);
    wait_wen(7, 100);
    k = hs_log.size();
    chk("t6_first_vreg", 32'(wr_log[5].vreg), 32'd1);
    chk("t6_second_vreg", 32'(wr_log[6].vreg), 32'd2);
    chk("t6_accept_after_wen", 32'(hs_log[k-1] - wen_log[5]), 32'd1);
    chk("t6_spacing", 32'(hs_log[k-1] - hs_log[k-2]), 32'd6);
    chk("t6_second_e3", 32'(wr_log[6].data[63:48]), 32'hA2A6);
    repeat (4) @(posedge clk);
    #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
